// File: rtl/display_request_scheduler_pkg.sv
// Shared types, constants and helpers for the display request scheduler.
// Double-dabble adjust and two's-complement magnitude live here so both the top and the bench-visible types agree.
package display_request_scheduler_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [6:0] SEG_MINUS   = 7'b0111111;
    localparam int         ITERATIONS  = 10;
    localparam int         BCD_WIDTH   = 12;
    localparam int         VALUE_WIDTH = 10;
    localparam int         DIGITS      = 3;

    typedef struct packed {
        logic                   sign;
        logic                   src;
        logic [VALUE_WIDTH-1:0] mag;
    } capture_t;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [BCD_WIDTH-1:0] bcd_adjust(input logic [BCD_WIDTH-1:0] bcd);
        logic [BCD_WIDTH-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
        end
        return r;
    endfunction

    // -512 maps to 10'h200, which is 512 read as unsigned.
    function automatic logic [VALUE_WIDTH-1:0] magnitude(input logic [VALUE_WIDTH-1:0] v);
        return v[VALUE_WIDTH-1] ? (~v + VALUE_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/display_request_scheduler_if.sv
// Requester handshakes and display pins of the scheduler, bundled with master/slave views.
interface display_request_scheduler_if;
    import display_request_scheduler_pkg::*;

    logic                   a_valid;
    logic [VALUE_WIDTH-1:0] a_value;
    logic                   a_ready;
    logic                   b_valid;
    logic [VALUE_WIDTH-1:0] b_value;
    logic                   b_ready;
    logic [6:0]             seg1_output;
    logic [6:0]             seg2_output;
    logic [6:0]             seg3_output;
    logic [6:0]             seg4_output;
    logic                   busy;
    logic                   display_source;

    modport master (
        output a_valid, a_value, b_valid, b_value,
        input  a_ready, b_ready, seg1_output, seg2_output, seg3_output, seg4_output,
               busy, display_source
    );

    modport slave (
        input  a_valid, a_value, b_valid, b_value,
        output a_ready, b_ready, seg1_output, seg2_output, seg3_output, seg4_output,
               busy, display_source
    );

endinterface

// File: rtl/display_request_scheduler_bcd_digit_encoder.sv
// One BCD digit to an active-low seven-segment pattern (bit0 = a .. bit6 = g); non-decimal codes blank.
module bcd_digit_encoder
    import display_request_scheduler_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_request_scheduler.sv
// Round-robin arbiter for two signed requesters sharing a 4-digit display; converts the winner
// to sign + 3 BCD digits over ten cycles and holds the latched result for HOLD_CYCLES.
module display_request_scheduler
    import display_request_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input logic                         clock,
    input logic                         reset,
    display_request_scheduler_if.slave  bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t                      state;
    logic                        prefer_b;
    logic [3:0]                  iter;
    logic [HW-1:0]               hold_cnt;
    capture_t                    cap;
    logic [BCD_WIDTH-1:0]        bcd;
    logic [BCD_WIDTH-1:0]        bcd_adj;
    logic [BCD_WIDTH-1:0]        bcd_next;
    logic [DIGITS-1:0][6:0]      digit_seg;
    logic                        grant_a;
    logic                        grant_b;
    logic                        handshake;
    logic [VALUE_WIDTH-1:0]      sel_value;

    // Single valid wins outright; with both valid the pointer breaks the tie.
    always_comb begin
        grant_a   = bus.a_valid && (!bus.b_valid || !prefer_b);
        grant_b   = bus.b_valid && (!bus.a_valid || prefer_b);
        sel_value = grant_a ? bus.a_value : bus.b_value;
        handshake = !reset && (state == IDLE) && (grant_a || grant_b);
    end

    assign bus.a_ready = handshake && grant_a;
    assign bus.b_ready = handshake && grant_b;
    assign bus.busy    = (state != IDLE);

    assign bcd_adj  = bcd_adjust(bcd);
    assign bcd_next = {bcd_adj[BCD_WIDTH-2:0], cap.mag[VALUE_WIDTH-1]};

    // Decoders watch the post-shift value so the final iteration's digits can be latched on that same edge.
    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        bcd_digit_encoder u_enc (
            .digit (bcd_next[g*4 +: 4]),
            .seg   (digit_seg[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            prefer_b           <= 1'b0;
            iter               <= '0;
            hold_cnt           <= '0;
            cap                <= '0;
            bcd                <= '0;
            bus.seg1_output    <= SEG_BLANK;
            bus.seg2_output    <= SEG_BLANK;
            bus.seg3_output    <= SEG_BLANK;
            bus.seg4_output    <= SEG_BLANK;
            bus.display_source <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cap.sign <= sel_value[VALUE_WIDTH-1];
                        cap.src  <= !grant_a;
                        cap.mag  <= magnitude(sel_value);
                        prefer_b <= grant_a;
                        bcd      <= '0;
                        iter     <= '0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd     <= bcd_next;
                    cap.mag <= {cap.mag[VALUE_WIDTH-2:0], 1'b0};
                    if (iter == 4'(ITERATIONS - 1)) begin
                        bus.seg1_output    <= digit_seg[0];
                        bus.seg2_output    <= digit_seg[1];
                        bus.seg3_output    <= digit_seg[2];
                        bus.seg4_output    <= cap.sign ? SEG_MINUS : SEG_BLANK;
                        bus.display_source <= cap.src;
                        hold_cnt           <= '0;
                        state              <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) state <= IDLE;
                    else                       hold_cnt <= hold_cnt + HW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_request_scheduler.sv
// Directed bench: HOLD_CYCLES=4 instance for most scenarios, HOLD_CYCLES=0 instance for back-to-back grants.
module tb_display_request_scheduler;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;

    // {seg4, seg3, seg2, seg1}
    localparam logic [27:0] EBL  = {BL, BL, BL, BL};
    localparam logic [27:0] E123 = {BL, D1, D2, D3};
    localparam logic [27:0] E512 = {MI, D5, D1, D2};
    localparam logic [27:0] EA5  = {BL, D0, D0, D5};
    localparam logic [27:0] EB40 = {MI, D0, D4, D0};
    localparam logic [27:0] E7   = {BL, D0, D0, D7};
    localparam logic [27:0] E99  = {BL, D0, D9, D9};
    localparam logic [27:0] E0   = {BL, D0, D0, D0};

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    display_request_scheduler_if bus4 ();
    display_request_scheduler_if bus0 ();

    display_request_scheduler #(.HOLD_CYCLES(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
    display_request_scheduler #(.HOLD_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] segs4();
        return {bus4.seg4_output, bus4.seg3_output, bus4.seg2_output, bus4.seg1_output};
    endfunction

    function automatic logic [27:0] segs0();
        return {bus0.seg4_output, bus0.seg3_output, bus0.seg2_output, bus0.seg1_output};
    endfunction

    // Called at a negedge with inputs already applied; returns just after the handshake edge.
    task automatic do_handshake(input string tag, input logic exp_a, input logic exp_b);
        #1;
        check($sformatf("%s_a_ready", tag), 32'(bus4.a_ready), 32'(exp_a));
        check($sformatf("%s_b_ready", tag), 32'(bus4.b_ready), 32'(exp_b));
        @(posedge clock);
        #1;
    endtask

    // Walks T+1..T+14 after a handshake and returns at the negedge of T+15.
    task automatic run_conv(input string tag, input logic [27:0] prev, input logic [27:0] exp, input logic src);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            check($sformatf("%s_conv%0d_segs", tag, i), 32'(segs4()), 32'(prev));
            check($sformatf("%s_conv%0d_busy", tag, i), 32'(bus4.busy), 32'd1);
            check($sformatf("%s_conv%0d_ready", tag, i), 32'(bus4.a_ready | bus4.b_ready), 32'd0);
        end
        @(negedge clock);
        check($sformatf("%s_result_segs", tag), 32'(segs4()), 32'(exp));
        check($sformatf("%s_result_src", tag), 32'(bus4.display_source), 32'(src));
        check($sformatf("%s_result_busy", tag), 32'(bus4.busy), 32'd1);
        for (int i = 12; i <= 14; i++) begin
            @(negedge clock);
            check($sformatf("%s_hold%0d_segs", tag, i), 32'(segs4()), 32'(exp));
            check($sformatf("%s_hold%0d_busy", tag, i), 32'(bus4.busy), 32'd1);
            check($sformatf("%s_hold%0d_ready", tag, i), 32'(bus4.a_ready | bus4.b_ready), 32'd0);
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus4.a_valid = 1'b1; bus4.a_value = 10'd5;
        bus4.b_valid = 1'b0; bus4.b_value = 10'd0;
        bus0.a_valid = 1'b0; bus0.a_value = 10'd0;
        bus0.b_valid = 1'b0; bus0.b_value = 10'd0;

        // Reset state, with a valid presented that must not be honoured
        repeat (2) @(negedge clock);
        #1;
        check("rst_a_ready", 32'(bus4.a_ready), 32'd0);
        check("rst_segs", 32'(segs4()), 32'(EBL));
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_src", 32'(bus4.display_source), 32'd0);
        check("rst_segs0", 32'(segs0()), 32'(EBL));
        bus4.a_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        // +123 from A; value scrambled after handshake must not matter
        bus4.a_valid = 1'b1; bus4.a_value = 10'd123;
        do_handshake("p123", 1'b1, 1'b0);
        bus4.a_valid = 1'b0; bus4.a_value = 10'h3FF;
        run_conv("p123", EBL, E123, 1'b0);
        check("p123_idle_busy", 32'(bus4.busy), 32'd0);

        // -512 from A
        bus4.a_valid = 1'b1; bus4.a_value = 10'h200;
        do_handshake("m512", 1'b1, 1'b0);
        bus4.a_valid = 1'b0;
        run_conv("m512", E123, E512, 1'b0);
        check("m512_idle_busy", 32'(bus4.busy), 32'd0);

        // Re-reset so the pointer prefers A, then both valid: A, B, A at 15-cycle spacing
        reset = 1'b1;
        @(negedge clock);
        check("rr_rst_segs", 32'(segs4()), 32'(EBL));
        reset = 1'b0;
        bus4.a_valid = 1'b1; bus4.a_value = 10'd5;
        bus4.b_valid = 1'b1; bus4.b_value = 10'h3D8;
        do_handshake("rr1", 1'b1, 1'b0);
        run_conv("rr1", EBL, EA5, 1'b0);
        do_handshake("rr2", 1'b0, 1'b1);
        run_conv("rr2", EA5, EB40, 1'b1);
        do_handshake("rr3", 1'b1, 1'b0);
        bus4.a_valid = 1'b0; bus4.b_valid = 1'b0;
        run_conv("rr3", EB40, EA5, 1'b0);

        // B raises valid in the second HOLD cycle of an A conversion
        bus4.a_valid = 1'b1; bus4.a_value = 10'd7;
        do_handshake("lh_a", 1'b1, 1'b0);
        bus4.a_valid = 1'b0;
        repeat (10) @(negedge clock);
        @(negedge clock);
        check("lh_t11_segs", 32'(segs4()), 32'(E7));
        @(negedge clock);
        bus4.b_valid = 1'b1; bus4.b_value = 10'd99;
        #1;
        for (int i = 12; i <= 14; i++) begin
            check($sformatf("lh_t%0d_b_ready", i), 32'(bus4.b_ready), 32'd0);
            check($sformatf("lh_t%0d_segs", i), 32'(segs4()), 32'(E7));
            @(negedge clock);
            #1;
        end
        do_handshake("lh_b", 1'b0, 1'b1);
        bus4.b_valid = 1'b0;
        run_conv("lh_b", E7, E99, 1'b1);
        check("lh_idle_busy", 32'(bus4.busy), 32'd0);

        // Reset during iteration 5 of +99, then a clean +7
        bus4.a_valid = 1'b1; bus4.a_value = 10'd99;
        do_handshake("ab99", 1'b1, 1'b0);
        bus4.a_valid = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ab_segs", 32'(segs4()), 32'(EBL));
        check("ab_busy", 32'(bus4.busy), 32'd0);
        check("ab_src", 32'(bus4.display_source), 32'd0);
        bus4.a_valid = 1'b1; bus4.a_value = 10'd7;
        do_handshake("ab7", 1'b1, 1'b0);
        bus4.a_valid = 1'b0;
        run_conv("ab7", EBL, E7, 1'b0);
        check("ab7_idle_busy", 32'(bus4.busy), 32'd0);

        // HOLD_CYCLES=0: +0 continuously, grants every 11 cycles
        bus0.a_valid = 1'b1; bus0.a_value = 10'd0;
        for (int h = 0; h < 3; h++) begin
            #1;
            check($sformatf("z%0d_a_ready", h), 32'(bus0.a_ready), 32'd1);
            @(posedge clock);
            for (int i = 1; i <= 10; i++) begin
                @(negedge clock);
                check($sformatf("z%0d_conv%0d_ready", h, i), 32'(bus0.a_ready), 32'd0);
                check($sformatf("z%0d_conv%0d_busy", h, i), 32'(bus0.busy), 32'd1);
            end
            @(negedge clock);
            check($sformatf("z%0d_segs", h), 32'(segs0()), 32'(E0));
            check($sformatf("z%0d_busy", h), 32'(bus0.busy), 32'd0);
            check($sformatf("z%0d_src", h), 32'(bus0.display_source), 32'd0);
        end
        bus0.a_valid = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
